// File: rtl/tx_arbiter.sv
// Two-requester round-robin front end for a byte sender: it accepts one byte,
// starts the sender and waits for completion with a timeout and flush.
module tx_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       req0_valid,
    input  logic       req1_valid,
    input  logic [7:0] req0_data,
    input  logic [7:0] req1_data,
    output logic       req0_ready,
    output logic       req1_ready,
    output logic       txEn,
    output logic       txStart,
    output logic [7:0] txData,
    input  logic       txBusy,
    input  logic       txDone,
    output logic [1:0] grant,
    output logic       done0,
    output logic       done1,
    output logic       timeout_err
);

    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned DATA_W = 8;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_RECOVER = 3'd3;
    localparam logic [2:0] S_FLUSH   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        grant_q, grant_d;
    logic              start_q, start_d;
    logic              en_q, en_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic              terr_q, terr_d;

    logic sel_c;
    logic can_accept_c;
    logic accept_c;

    // Round robin: on a tie the requester not served last wins.
    assign sel_c        = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    assign can_accept_c = enable && (state_q == S_IDLE) && !txBusy;
    assign accept_c     = can_accept_c && (req0_valid || req1_valid);

    assign req0_ready = can_accept_c && req0_valid && !sel_c;
    assign req1_ready = can_accept_c && req1_valid && sel_c;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        data_d  = data_q;
        grant_d = grant_q;
        done0_d = 1'b0;
        done1_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    data_d  = sel_c ? req1_data : req0_data;
                    grant_d = sel_c ? 2'b10 : 2'b01;
                    last_d  = sel_c;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (!enable) begin
                    grant_d = 2'b00;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Losing enable wins over a completion arriving in the same cycle.
                if (!enable) begin
                    grant_d = 2'b00;
                    state_d = S_IDLE;
                end else if (txDone) begin
                    done0_d = grant_q[0];
                    done1_d = grant_q[1];
                    grant_d = 2'b00;
                    state_d = S_RECOVER;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    grant_d = 2'b00;
                    state_d = S_FLUSH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RECOVER: begin
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
            S_FLUSH: begin
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
        endcase

        start_d = (state_d == S_START);
        en_d    = enable && (state_d != S_FLUSH);
        terr_d  = (state_d == S_FLUSH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            data_q  <= '0;
            grant_q <= 2'b00;
            start_q <= 1'b0;
            en_q    <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            start_q <= start_d;
            en_q    <= en_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            terr_q  <= terr_d;
        end
    end

    assign txEn        = en_q;
    assign txStart     = start_q;
    assign txData      = data_q;
    assign grant       = grant_q;
    assign done0       = done0_q;
    assign done1       = done1_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Scenario bench for tx_arbiter: frame timing is predicted from the protocol
// rules (start one cycle after acceptance, done one cycle after txDone, flush after 16 WAIT cycles).
module tb_tx_arbiter;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       txEn, txStart;
    logic [7:0] txData;
    logic       txBusy, txDone;
    logic [1:0] grant;
    logic       done0, done1, timeout_err;

    int total;
    int bad;

    tx_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .req0_valid  (req0_valid),
        .req1_valid  (req1_valid),
        .req0_data   (req0_data),
        .req1_data   (req1_data),
        .req0_ready  (req0_ready),
        .req1_ready  (req1_ready),
        .txEn        (txEn),
        .txStart     (txStart),
        .txData      (txData),
        .txBusy      (txBusy),
        .txDone      (txDone),
        .grant       (grant),
        .done0       (done0),
        .done1       (done1),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = 8'h00; req1_data = 8'h00; txBusy = 1'b0; txDone = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        enable = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = 8'h00; req1_data = 8'h00; txBusy = 1'b0; txDone = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++; if (txEn !== 1'b0) begin bad++; $display("FAIL reset_txEn got=%b exp=0", txEn); end
        total++; if (txStart !== 1'b0) begin bad++; $display("FAIL reset_txStart got=%b exp=0", txStart); end
        total++; if (txData !== 8'h00) begin bad++; $display("FAIL reset_txData got=%h exp=00", txData); end
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b exp=00", grant); end
        total++; if ({done1, done0, timeout_err} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b exp=000", {done1, done0, timeout_err}); end
        tick();
        total++; if (txEn !== 1'b0) begin bad++; $display("FAIL reset_hold_txEn got=%b exp=0", txEn); end
        rst = 1'b0;
        tick();
        total++; if (txEn !== 1'b1) begin bad++; $display("FAIL reset_release_txEn got=%b exp=1", txEn); end
    endtask

    task automatic test_single(input logic [7:0] data, input int d);
        do_reset();
        enable = 1'b1;
        tick();
        req0_valid = 1'b1; req0_data = data;
        #1;
        total++; if ({req1_ready, req0_ready} !== 2'b01) begin bad++; $display("FAIL single_ready got=%b exp=01", {req1_ready, req0_ready}); end
        tick();
        req0_valid = 1'b0; req0_data = ~data;
        total++; if (txStart !== 1'b1) begin bad++; $display("FAIL single_start got=%b exp=1", txStart); end
        total++; if (txData !== data) begin bad++; $display("FAIL single_data got=%h exp=%h", txData, data); end
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL single_grant got=%b exp=01", grant); end
        for (int k = 1; k <= d; k++) begin
            tick();
            txDone = (k == d);
            total++; if ({txStart, done1, done0} !== 3'b000) begin bad++; $display("FAIL single_wait k=%0d got=%b exp=000", k, {txStart, done1, done0}); end
            total++; if (txData !== data) begin bad++; $display("FAIL single_hold k=%0d got=%h exp=%h", k, txData, data); end
        end
        tick();
        txDone = 1'b0;
        total++; if ({done1, done0} !== 2'b01) begin bad++; $display("FAIL single_done got=%b exp=01", {done1, done0}); end
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL single_grant_clr got=%b exp=00", grant); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL single_terr got=%b exp=0", timeout_err); end
        tick();
        total++; if ({done1, done0} !== 2'b00) begin bad++; $display("FAIL single_done_pulse got=%b exp=00", {done1, done0}); end
    endtask

    task automatic test_contention();
        logic exp_last;
        logic owner;
        int   n;
        int   d;
        logic [7:0] exp_data;
        do_reset();
        enable = 1'b1;
        tick();
        exp_last = 1'b1;
        d = 0;
        req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 8'h11; req1_data = 8'h22;
        for (int f = 0; f < 4; f++) begin
            n = 0;
            while (txStart !== 1'b1 && n < 40) begin
                tick();
                n++;
            end
            total++; if (n !== ((f == 0) ? 1 : 2)) begin bad++; $display("FAIL cont_spacing f=%0d got=%0d exp=%0d", f, n, (f == 0) ? 1 : 2); end
            owner = ~exp_last;
            exp_data = owner ? 8'h22 : 8'h11;
            total++; if (txData !== exp_data) begin bad++; $display("FAIL cont_data f=%0d got=%h exp=%h", f, txData, exp_data); end
            total++; if (grant !== (owner ? 2'b10 : 2'b01)) begin bad++; $display("FAIL cont_grant f=%0d got=%b owner=%0d", f, grant, owner); end
            exp_last = owner;
            d = int'($urandom_range(1, 16));
            for (int k = 1; k <= d; k++) begin
                tick();
                txDone = (k == d);
                total++; if ({req1_ready, req0_ready} !== 2'b00) begin bad++; $display("FAIL cont_ready_busy f=%0d got=%b exp=00", f, {req1_ready, req0_ready}); end
            end
            tick();
            txDone = 1'b0;
            total++; if ({done1, done0} !== (owner ? 2'b10 : 2'b01)) begin bad++; $display("FAIL cont_done f=%0d got=%b owner=%0d", f, {done1, done0}, owner); end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_timeout();
        logic [7:0] data;
        data = 8'($urandom_range(0, 255));
        do_reset();
        enable = 1'b1;
        tick();
        req1_valid = 1'b1; req1_data = data;
        tick();
        req1_valid = 1'b0;
        total++; if (grant !== 2'b10) begin bad++; $display("FAIL to_grant got=%b exp=10", grant); end
        for (int k = 1; k <= 16; k++) begin
            tick();
            total++; if ({txEn, timeout_err, done1, done0} !== 4'b1000) begin bad++; $display("FAIL to_wait k=%0d got=%b exp=1000", k, {txEn, timeout_err, done1, done0}); end
        end
        tick();
        total++; if ({txEn, timeout_err} !== 2'b01) begin bad++; $display("FAIL to_flush got=%b exp=01", {txEn, timeout_err}); end
        total++; if ({grant, done1, done0, txStart} !== 5'b00000) begin bad++; $display("FAIL to_flush_clr got=%b exp=00000", {grant, done1, done0, txStart}); end
        req0_valid = 1'b1; req0_data = 8'h5C;
        #1;
        total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL to_flush_ready got=%b exp=0", req0_ready); end
        tick();
        total++; if ({txEn, timeout_err} !== 2'b10) begin bad++; $display("FAIL to_after got=%b exp=10", {txEn, timeout_err}); end
        total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL to_next_ready got=%b exp=1", req0_ready); end
        tick();
        req0_valid = 1'b0;
        total++; if ({txStart, grant} !== 3'b101) begin bad++; $display("FAIL to_next_start got=%b exp=101", {txStart, grant}); end
        total++; if (txData !== 8'h5C) begin bad++; $display("FAIL to_next_data got=%h exp=5c", txData); end
    endtask

    task automatic test_enable_drop();
        int k;
        k = int'($urandom_range(0, 6));
        do_reset();
        enable = 1'b1;
        tick();
        req0_valid = 1'b1; req0_data = 8'h3E;
        tick();
        req0_valid = 1'b0;
        for (int i = 0; i < k; i++) tick();
        enable = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        total++; if ({req1_ready, req0_ready} !== 2'b00) begin bad++; $display("FAIL en_ready got=%b exp=00", {req1_ready, req0_ready}); end
        tick();
        txDone = 1'b1;
        total++; if ({txEn, grant} !== 3'b000) begin bad++; $display("FAIL en_abort k=%0d got=%b exp=000", k, {txEn, grant}); end
        total++; if ({done1, done0, timeout_err, txStart} !== 4'b0000) begin bad++; $display("FAIL en_pulses k=%0d got=%b exp=0000", k, {done1, done0, timeout_err, txStart}); end
        for (int i = 0; i < 3; i++) begin
            tick();
            txDone = 1'b0;
            total++; if ({req1_ready, req0_ready, txStart, done1, done0, grant} !== 7'b0) begin bad++; $display("FAIL en_idle i=%0d got=%b exp=0000000", i, {req1_ready, req0_ready, txStart, done1, done0, grant}); end
        end
        enable = 1'b1;
        #1;
        total++; if ({req1_ready, req0_ready} !== 2'b10) begin bad++; $display("FAIL en_rr_ready got=%b exp=10", {req1_ready, req0_ready}); end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        total++; if ({txEn, txStart, grant} !== 4'b1110) begin bad++; $display("FAIL en_resume got=%b exp=1110", {txEn, txStart, grant}); end
    endtask

    task automatic test_async_reset();
        do_reset();
        enable = 1'b1;
        tick();
        req1_valid = 1'b1; req1_data = 8'hC3;
        tick();
        req1_valid = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        total++; if ({txEn, txStart, grant, done1, done0, timeout_err} !== 7'b0) begin bad++; $display("FAIL ar_ctrl got=%b exp=0000000", {txEn, txStart, grant, done1, done0, timeout_err}); end
        total++; if (txData !== 8'h00) begin bad++; $display("FAIL ar_data got=%h exp=00", txData); end
        #2 rst = 1'b0;
        txDone = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            txDone = 1'b0;
            total++; if ({txEn, txStart, grant, done1, done0, timeout_err} !== 7'b1000000) begin bad++; $display("FAIL ar_stale i=%0d got=%b exp=1000000", i, {txEn, txStart, grant, done1, done0, timeout_err}); end
        end
        req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 8'h77; req1_data = 8'h88;
        #1;
        total++; if ({req1_ready, req0_ready} !== 2'b01) begin bad++; $display("FAIL ar_rr_ready got=%b exp=01", {req1_ready, req0_ready}); end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        total++; if ({txStart, grant, txData} !== {1'b1, 2'b01, 8'h77}) begin bad++; $display("FAIL ar_resume got=%b/%b/%h exp=1/01/77", txStart, grant, txData); end
    endtask

    task automatic test_busy();
        logic [7:0] data;
        data = 8'($urandom_range(0, 255));
        do_reset();
        enable = 1'b1;
        tick();
        txBusy = 1'b1; req1_valid = 1'b1; req1_data = data;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL busy_ready i=%0d got=%b exp=0", i, req1_ready); end
            tick();
            total++; if ({txStart, grant} !== 3'b000) begin bad++; $display("FAIL busy_noaccept i=%0d got=%b exp=000", i, {txStart, grant}); end
        end
        txBusy = 1'b0;
        #1;
        total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL busy_release_ready got=%b exp=1", req1_ready); end
        tick();
        req1_valid = 1'b0;
        total++; if ({txStart, grant, txData} !== {1'b1, 2'b10, data}) begin bad++; $display("FAIL busy_accept got=%b/%b/%h exp=1/10/%h", txStart, grant, txData, data); end
    endtask

    task automatic test_random(input int n);
        logic       exp_last;
        logic       exp_sel;
        logic [1:0] r;
        logic [7:0] d0, d1, exp_data;
        logic [1:0] exp_done;
        int         d, lim;
        do_reset();
        enable = 1'b1;
        tick();
        exp_last = 1'b1;
        for (int f = 0; f < n; f++) begin
            r  = 2'($urandom_range(1, 3));
            d0 = 8'($urandom_range(0, 255));
            d1 = 8'($urandom_range(0, 255));
            exp_sel  = (r[0] && r[1]) ? ~exp_last : r[1];
            exp_data = exp_sel ? d1 : d0;
            exp_done = exp_sel ? 2'b10 : 2'b01;
            req0_valid = r[0]; req1_valid = r[1]; req0_data = d0; req1_data = d1;
            #1;
            total++; if ({req1_ready, req0_ready} !== {r[1] && exp_sel, r[0] && !exp_sel}) begin bad++; $display("FAIL rnd_ready f=%0d got=%b valid=%b", f, {req1_ready, req0_ready}, r); end
            tick();
            req0_valid = 1'b0; req1_valid = 1'b0;
            total++; if ({txStart, grant, txData} !== {1'b1, exp_done, exp_data}) begin bad++; $display("FAIL rnd_start f=%0d got=%b/%b/%h exp=1/%b/%h", f, txStart, grant, txData, exp_done, exp_data); end
            exp_last = exp_sel;
            d   = int'($urandom_range(1, 20));
            lim = (d > 16) ? 16 : d;
            for (int k = 1; k <= lim; k++) begin
                tick();
                txDone = (k == d);
                req0_data = 8'($urandom_range(0, 255));
                req1_data = 8'($urandom_range(0, 255));
                total++; if ({txData, done1, done0} !== {exp_data, 2'b00}) begin bad++; $display("FAIL rnd_wait f=%0d k=%0d got=%h/%b exp=%h/00", f, k, txData, {done1, done0}, exp_data); end
            end
            tick();
            txDone = 1'b0;
            if (d <= 16) begin
                total++; if ({done1, done0, timeout_err, grant} !== {exp_done, 3'b000}) begin bad++; $display("FAIL rnd_done f=%0d d=%0d got=%b exp=%b000", f, d, {done1, done0, timeout_err, grant}, exp_done); end
            end else begin
                total++; if ({txEn, timeout_err, done1, done0, grant} !== 6'b010000) begin bad++; $display("FAIL rnd_flush f=%0d got=%b exp=010000", f, {txEn, timeout_err, done1, done0, grant}); end
            end
            tick();
            total++; if ({txEn, timeout_err, done1, done0} !== 4'b1000) begin bad++; $display("FAIL rnd_idle f=%0d got=%b exp=1000", f, {txEn, timeout_err, done1, done0}); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single(8'hA5, 11);
        test_single(8'($urandom_range(0, 255)), int'($urandom_range(1, 16)));
        test_single(8'h3C, 16);
        test_contention();
        test_timeout();
        test_enable_drop();
        test_async_reset();
        test_busy();
        test_random(40);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: cycles allowed in WAIT before the frame is aborted.
REQ-002 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port enable  input  1  global enable for the arbiter and the sender.
REQ-005 SHALL have ports req0_valid/req1_valid  input  1  requester has a byte.
REQ-006 SHALL have ports req0_data/req1_data  input  8  requester byte.
REQ-007 SHALL have ports req0_ready/req1_ready  output  1  byte accepted when valid and ready are high in the same cycle.
REQ-008 SHALL have port txEn  output  1  sender enable.
REQ-009 SHALL have port txStart  output  1  sender start pulse.
REQ-010 SHALL have port txData  output  8  byte to the sender.
REQ-011 SHALL have port txBusy  input  1  sender busy.
REQ-012 SHALL have port txDone  input  1  sender frame-complete pulse.
REQ-013 SHALL have port grant  output  2  one-hot owner of the in-flight frame; 00 when idle.
REQ-014 SHALL have ports done0/done1  output  1  one-cycle completion pulse per requester.
REQ-015 SHALL have port timeout_err  output  1  one-cycle pulse on abort.

Function
REQ-016 SHALL implement states IDLE, START, WAIT, RECOVER, FLUSH.
REQ-017 SHALL drive readyN combinationally = enable && state==IDLE && !txBusy && (selected requester == N).
- All other outputs SHALL be registered.
REQ-018 SHALL select the requester by round robin:
- only one valid: select it;
- both valid: select the requester not served last;
- last-served pointer after reset = 1, so requester 0 wins the first tie.
REQ-019 On acceptance in IDLE, SHALL latch reqN_data into txData, set grant to the one-hot of N, update the last-served pointer to N, and go to START.
REQ-020 In START, SHALL assert txStart for exactly one cycle, visible in the cycle after acceptance, then go to WAIT.
- txStart SHALL be 0 in every other state.
REQ-021 In WAIT, SHALL count cycles from 0.
- txDone==1 → pulse doneN (N = grant owner) in the next cycle, clear grant, go to RECOVER.
REQ-022 RECOVER SHALL last one cycle, then go to IDLE.
- Guarantees txStart is never asserted while the sender is still clearing txBusy.
REQ-023 In WAIT, if the counter reaches TIMEOUT_CYCLES-1 with no txDone, SHALL go to FLUSH.
REQ-024 In FLUSH (one cycle), SHALL:
- drive txEn=0 to reset the sender;
- pulse timeout_err;
- clear grant;
- assert no doneN;
- go to IDLE.
REQ-025 txEn SHALL equal enable registered, forced 0 during FLUSH.
REQ-026 If enable falls in START, WAIT or RECOVER, SHALL abort to IDLE next cycle and clear grant, with no doneN and no timeout_err.
REQ-027 A txDone arriving in any state other than WAIT SHALL be ignored.
REQ-028 The timeout counter SHALL be wide enough for TIMEOUT_CYCLES and SHALL clear on entry to WAIT.
REQ-029 Input valid/data changes after acceptance SHALL NOT affect txData until the next acceptance.
REQ-030 Back-to-back frames SHALL be spaced by at least one RECOVER cycle plus one IDLE cycle.

Reset
REQ-031 While rst=1, SHALL hold these values asynchronously: state=IDLE, txEn=0, txStart=0, txData=0, grant=00, done0=done1=0, timeout_err=0, counter=0, last-served=1.
REQ-032 Reset asserted mid-frame SHALL take effect immediately with no done or error pulse.
- Frame resumes from IDLE after rst deasserts.

Verification
REQ-033 Single request: enable=1, req0_valid=1, req0_data=0xA5, sender model gives txDone 11 cycles after txStart → expect:
- txStart one cycle, txData=0xA5, grant=01;
- done0 one cycle after txDone, then grant=00.
REQ-034 Contention: both valid continuously, data 0x11/0x22 → serve order 0,1,0,1; txData alternates 0x11,0x22; done pulses alternate.
REQ-035 Timeout: TIMEOUT_CYCLES=16, sender never pulses txDone → expect:
- FLUSH 16 cycles after WAIT entry;
- txEn=0 for one cycle, timeout_err one cycle;
- no done1/done0; next request then served.
REQ-036 Enable drop: enable=0 during WAIT → IDLE next cycle, txEn=0, grant=00, no done/error pulses; ready0/ready1 low while enable=0.
REQ-037 Async reset mid-frame: rst pulse during WAIT → outputs at reset values before the next clk edge; the stale txDone that follows is ignored.
REQ-038 Busy guard: txBusy held 1 while in IDLE with req1_valid=1 → req1_ready=0 and no acceptance until txBusy=0.
